// File: rtl/cbrt_pkg.sv
// cbrt_pkg: shared definitions for the iterative cube-root unit.
//   OUT_W    : result width (one result bit per iteration)
//   IN_W     : radicand width, always 3*OUT_W
//   S_INIT   : first shift amount applied to the remainder
//   S_STEP   : shift decrement per iteration (one root bit = three radicand bits)
//   ITER_CYC : clock edges per iteration (PREP + OUT_W+1 MUL + CMP)
//   state_e  : controller state encoding
package cbrt_pkg;
    localparam int OUT_W    = 8;
    localparam int IN_W     = 3 * OUT_W;
    localparam int S_INIT   = IN_W - 3;
    localparam int S_STEP   = 3;
    localparam int ITER_CYC = OUT_W + 3;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        MUL  = 2'd2,
        CMP  = 2'd3
    } state_e;
endpackage

// File: rtl/mul_shift_add.sv
// mul_shift_add: sequential shift-add multiplier, one multiplier bit per cycle.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   start_i : load operands (accepted only when not busy)
//   a_bi    : multiplier, OUT_W bits
//   b_bi    : multiplicand, OUT_W+1 bits
//   busy_o  : high while the product is being accumulated; falls on the edge
//             the product becomes valid
//   y_bo    : product, 2*OUT_W+1 bits (valid while busy_o is low after a run)
// The start edge loads the operands and OUT_W further edges accumulate, so a
// consumer that presents start in cycle c can use the product OUT_W+1 cycles
// later.
module mul_shift_add #(
    parameter int OUT_W = 8
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               start_i,
    input  logic [OUT_W-1:0]   a_bi,
    input  logic [OUT_W:0]     b_bi,
    output logic               busy_o,
    output logic [2*OUT_W:0]   y_bo
);
    localparam int P_W   = 2 * OUT_W + 1;
    localparam int CNT_W = $clog2(OUT_W + 1);

    logic [P_W-1:0]   mcand_q,  mcand_d;
    logic [OUT_W-1:0] mplier_q, mplier_d;
    logic [P_W-1:0]   acc_q,    acc_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             busy_q,   busy_d;

    always_comb begin
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        busy_d   = busy_q;
        if (busy_q) begin
            if (mplier_q[0]) begin
                acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q - 1'b1;
            if (cnt_q == CNT_W'(1)) begin
                busy_d = 1'b0;
            end
        end else if (start_i) begin
            mcand_d  = P_W'(b_bi);
            mplier_d = a_bi;
            acc_d    = '0;
            cnt_d    = CNT_W'(OUT_W);
            busy_d   = 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
        end else begin
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            busy_q   <= busy_d;
        end
    end

    assign busy_o = busy_q;
    assign y_bo   = acc_q;
endmodule

// File: rtl/cbrt.sv
// cbrt: iterative integer cube root, y_bo = floor(cbrt(a_bi)).
// Digit-by-digit: each iteration doubles the partial root y, forms
// b = 3*y*(y+1)+1 with the shared multiplier and, if the remainder window
// x>>s can hold b, subtracts b<<s and sets the new root bit.
// Ports:
//   clk_i   : clock
//   rst_i   : synchronous active-high reset (abandons any computation)
//   a_bi    : radicand, sampled only on the accepting start edge
//   start_i : request, level-sampled in IDLE
//   busy_o  : high while a computation is in flight
//   y_bo    : last completed result
module cbrt #(
    parameter int OUT_W = cbrt_pkg::OUT_W,
    parameter int IN_W  = cbrt_pkg::IN_W
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [IN_W-1:0]  a_bi,
    input  logic             start_i,
    output logic             busy_o,
    output logic [OUT_W-1:0] y_bo
);
    import cbrt_pkg::*;

    if (IN_W != 3 * OUT_W) begin : g_width_check
        $error("cbrt: IN_W must equal 3*OUT_W");
    end

    localparam int S_W    = $clog2(IN_W);
    localparam int P_W    = 2 * OUT_W + 1;
    localparam int B_W    = 2 * OUT_W + 2;
    localparam int S_FIRST = IN_W - S_STEP;

    state_e           state_q, state_d;
    logic [IN_W-1:0]  x_q,     x_d;
    logic [OUT_W-1:0] y_q,     y_d;
    logic [S_W-1:0]   s_q,     s_d;
    logic [B_W-1:0]   b_q,     b_d;
    logic             busy_q,  busy_d;
    logic [OUT_W-1:0] y_out_q, y_out_d;

    logic             m_start;
    logic [OUT_W-1:0] m_a;
    logic [OUT_W:0]   m_b;
    logic             m_busy;
    logic [P_W-1:0]   m_p;

    logic [IN_W-1:0]  b_ext;
    logic             fits;
    logic [OUT_W-1:0] y_inc;

    // Operands are formed from the pre-shift y so they match the y<<1 that
    // PREP writes back. 2y is even, so 2y+1 just sets the LSB.
    assign m_start = (state_q == PREP);
    assign m_a     = {y_q[OUT_W-2:0], 1'b0};
    assign m_b     = {1'b0, y_q[OUT_W-2:0], 1'b1};

    mul_shift_add #(
        .OUT_W (OUT_W)
    ) u_mul (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .start_i (m_start),
        .a_bi    (m_a),
        .b_bi    (m_b),
        .busy_o  (m_busy),
        .y_bo    (m_p)
    );

    // Compare against x>>s rather than b<<s so nothing overflows; when the
    // compare passes, b<<s is bounded by x and fits in IN_W.
    assign b_ext = IN_W'(b_q);
    assign fits  = (x_q >> s_q) >= b_ext;
    assign y_inc = fits ? (y_q + OUT_W'(1)) : y_q;

    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        s_d     = s_q;
        b_d     = b_q;
        busy_d  = busy_q;
        y_out_d = y_out_q;
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    x_d     = a_bi;
                    y_d     = '0;
                    s_d     = S_W'(S_FIRST);
                    busy_d  = 1'b1;
                    state_d = PREP;
                end
            end
            PREP: begin
                y_d     = y_q << 1;
                state_d = MUL;
            end
            MUL: begin
                // The multiplier went busy on the PREP edge, so low here
                // means the product is ready.
                if (!m_busy) begin
                    b_d     = (B_W'(m_p) << 1) + B_W'(m_p) + B_W'(1);
                    state_d = CMP;
                end
            end
            CMP: begin
                if (fits) begin
                    x_d = x_q - (b_ext << s_q);
                end
                y_d = y_inc;
                if (s_q == '0) begin
                    y_out_d = y_inc;
                    busy_d  = 1'b0;
                    state_d = IDLE;
                end else begin
                    s_d     = s_q - S_W'(S_STEP);
                    state_d = PREP;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            x_q     <= '0;
            y_q     <= '0;
            s_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            y_out_q <= '0;
        end else begin
            state_q <= state_d;
            x_q     <= x_d;
            y_q     <= y_d;
            s_q     <= s_d;
            b_q     <= b_d;
            busy_q  <= busy_d;
            y_out_q <= y_out_d;
        end
    end

    assign busy_o = busy_q;
    assign y_bo   = y_out_q;
endmodule

// File: tb/tb_cbrt.sv
// tb_cbrt: randomized and directed stimulus for cbrt with a queue scoreboard.
// The driver pushes floor(cbrt(a)) for every accepted start; the monitor pops
// and compares on every busy_o falling edge, also checking the 88-cycle run.
module tb_cbrt;
    localparam int LAT = 88;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic [23:0] a_bi  = '0;
    logic        start_i = 1'b0;
    logic        busy_o;
    logic [7:0]  y_bo;

    int tests = 0;
    int fails = 0;

    logic [7:0]  exp_q[$];
    logic [23:0] arg_q[$];
    logic        abort_flag = 1'b0;
    logic        prev_busy  = 1'b0;
    int          run_len    = 0;

    cbrt dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .a_bi    (a_bi),
        .start_i (start_i),
        .busy_o  (busy_o),
        .y_bo    (y_bo)
    );

    always #5 clk_i = ~clk_i;

    // Reference: largest r with r*r*r <= a, by plain search.
    function automatic logic [7:0] ref_cbrt(input logic [23:0] a);
        longint r = 0;
        while ((r + 1) * (r + 1) * (r + 1) <= longint'(a)) r++;
        return 8'(r);
    endfunction

    task automatic check(input string name, input longint act, input longint req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, req);
        end
    endtask

    // Monitor: samples on the falling edge, away from the active edge.
    always @(negedge clk_i) begin
        if (busy_o === 1'b1) begin
            run_len++;
        end else if (prev_busy) begin
            if (abort_flag) begin
                run_len = 0;
            end else if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_done: got y=%0d expected no completion", y_bo);
                run_len = 0;
            end else begin
                logic [7:0]  e;
                logic [23:0] a;
                e = exp_q.pop_front();
                a = arg_q.pop_front();
                tests++;
                if (y_bo !== e) begin
                    fails++;
                    $display("FAIL result a=%0d: got %0d expected %0d", a, y_bo, e);
                end else begin
                    $display("[TB] a=%0d y=%0d ok", a, y_bo);
                end
                check("busy_len", run_len, LAT);
                run_len = 0;
            end
        end
        prev_busy = (busy_o === 1'b1);
    end

    // Drive start for one accepting edge without scoring anything.
    task automatic pulse_start(input logic [23:0] a);
        @(negedge clk_i);
        a_bi    = a;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
    endtask

    task automatic start_op(input logic [23:0] a);
        exp_q.push_back(ref_cbrt(a));
        arg_q.push_back(a);
        pulse_start(a);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (busy_o !== 1'b0) begin
            @(negedge clk_i);
            n++;
            if (n > 200) begin
                tests++;
                fails++;
                $display("FAIL wait_idle: got busy after %0d cycles expected idle", n);
                return;
            end
        end
    endtask

    task automatic run_one(input logic [23:0] a);
        start_op(a);
        wait_idle();
    endtask

    initial begin
        logic [23:0] bnd[8];
        logic [23:0] a;
        int          r;
        int          n;
        bnd = '{24'd0, 24'd1, 24'd7, 24'd8, 24'd26, 24'd27, 24'd16581375, 24'd16777215};

        repeat (3) @(negedge clk_i);
        rst_i = 1'b0;
        check("reset_busy", busy_o, 0);
        check("reset_y", y_bo, 0);

        // Pow3 bench value.
        run_one(24'd512);

        // Boundaries.
        foreach (bnd[i]) run_one(bnd[i]);

        // Second start during a computation is ignored; a_bi changes too.
        start_op(24'd1000);
        repeat (28) @(negedge clk_i);
        a_bi    = 24'd8;
        start_i = 1'b1;
        @(negedge clk_i);
        start_i = 1'b0;
        wait_idle();
        @(negedge clk_i);
        check("ignored_start_busy", busy_o, 0);

        // Reset mid-operation abandons the run and clears the result.
        pulse_start(24'd1000);
        repeat (38) @(negedge clk_i);
        abort_flag = 1'b1;
        rst_i      = 1'b1;
        @(negedge clk_i);
        rst_i = 1'b0;
        check("abort_busy", busy_o, 0);
        check("abort_y", y_bo, 0);
        @(negedge clk_i);
        abort_flag = 1'b0;
        run_one(24'd125);

        // start_i held high: back-to-back runs with a one-cycle idle gap.
        exp_q.push_back(ref_cbrt(24'd64));  arg_q.push_back(24'd64);
        exp_q.push_back(ref_cbrt(24'd343)); arg_q.push_back(24'd343);
        @(negedge clk_i);
        a_bi    = 24'd64;
        start_i = 1'b1;
        @(negedge clk_i);
        n = 0;
        while (busy_o !== 1'b0 && n < 200) begin
            @(negedge clk_i);
            n++;
        end
        check("held_first_done", busy_o, 0);
        a_bi = 24'd343;
        @(negedge clk_i);
        check("held_gap_one_cycle", busy_o, 1);
        start_i = 1'b0;
        wait_idle();

        // Loopback: every exact cube must return its root.
        for (int v = 0; v < 256; v++) run_one(24'(v * v * v));

        // Random vectors: half uniform, half on either side of a cube.
        for (int k = 0; k < 400; k++) begin
            if (k[0]) begin
                a = 24'($urandom_range(0, 24'hFFFFFF));
            end else begin
                r = int'($urandom_range(1, 255));
                a = 24'(r * r * r - int'($urandom_range(0, 1)));
            end
            run_one(a);
        end

        repeat (3) @(negedge clk_i);
        check("queue_drained", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
